cdb_arbiter: RTL and testbench
==============================

// Module: cdb_arbiter
// PURPOSE
//  Transmit side of the common data bus: the producer end of the `cdb` struct consumed by reservation stations and ROB.
//  Accepts to_writeback_t results from the execution units (alu, mul, div, br, mem) through per-source valid/ready.
//  Buffers each source in a small FIFO; round-robin grants one result per cycle onto the registered broadcast half of cdb_o.
//  Commit half of cdb_o is a same-cycle pass-through of the ROB's to_commit_t.
// PARAMETERS
//  N_SRC      5  number of producer units; index = types_t value - 1 (alu=0, mul=1, div=2, br=3, mem=4)
//  FIFO_DEPTH 2  entries per source FIFO; power of two, >= 2
// PORTS
//  clk        in   1                  clock, all state on rising edge
//  rst        in   1                  synchronous, active-high reset
//  flush      in   1                  mispredict squash; clears all buffered results
//  src_valid  in   [N_SRC]            producer i presents a result
//  src_data   in   to_writeback_t[N_SRC] result payload per producer
//  src_ready  out  [N_SRC]            FIFO i can accept this cycle
//  commit_i   in   to_commit_t        ROB commit info for this cycle
//  cdb_o      out  cdb                broadcast + commit bus
// BEHAVIOUR
//  - Push: src_valid[i] && src_ready[i] at an edge writes src_data[i] into FIFO i; payload with valid=0 ignored.
//  - src_ready[i] = (count_i < FIFO_DEPTH) && !flush && !rst; no pop-through on full FIFO (depends on state only).
//  - Arbitration (combinational on FIFO heads): candidates = non-empty FIFOs; search starts at (last_grant+1) mod N_SRC.
//    Winner is popped at the edge; last_grant <= winner; last_grant unchanged when no candidate.
//  - Broadcast register, loaded every edge: valid<=any candidate; data<=head.rd_data; rob_idx<=head.rd_rob_idx;
//    rd_addr<=head.rd_addr; regf_we<=head.regf_we. No candidate -> valid<=0, other broadcast fields <=0.
//  - Results with regf_we=0 (stores, branches) are still broadcast so the ROB marks them done.
//  - Latency: push at edge k -> earliest cdb_o.valid after edge k+1 (2-edge fixed minimum); each result broadcast exactly once, one cycle.
//  - Per-source order preserved (FIFO); cross-source order set only by round-robin.
//  - commit_data/commit_rob_idx/commit_rd_addr = commit_i.rd_data/rd_rob_idx/rd_addr, combinational; zero when !commit_i.valid.
//  - flush: at the edge all FIFO counts/pointers <=0, broadcast valid<=0, pushes in that cycle dropped; last_grant kept.
//    Commit pass-through unaffected by flush.
//  - rst: FIFOs empty, last_grant<=N_SRC-1 (source 0 first), all broadcast fields 0; src_ready 0 during rst, 1 after.
//  - Counters/pointers wrap mod FIFO_DEPTH; count width $clog2(FIFO_DEPTH)+1; never over/underflows by construction.
//  - Simultaneous push and pop on same non-full FIFO: count unchanged, both take effect.
// STRUCTURE
//  - rv32i_types: add localparam N_CDB_SRC=5 and CDB_SRC_ALU..CDB_SRC_MEM index constants (types_t - 1).
//  - Sub-module cdb_src_fifo (to_writeback_t payload, DEPTH param, push/pop/flush, head, count), instanced N_SRC times.
//  - Arbiter, last_grant register and broadcast register live in cdb_arbiter.
// TESTING
//  1. rst 2 cycles -> cdb_o all zero, src_ready=5'b00000 during rst, 5'b11111 first cycle after.
//  2. alu push rob_idx=3, rd_addr=7, data=32'hDEADBEEF, regf_we=1 at edge k -> cdb_o.valid=1 with those values only after edge k+1.
//  3. All 5 sources push once same edge -> broadcast order alu,mul,div,br,mem on 5 consecutive cycles, no gaps;
//     next lone mul push after that wins immediately (last_grant=mem).
//  4. All sources push every cycle 20 cycles -> src_ready[i] drops when count=2; each source gets 1 grant per 5 cycles;
//     scoreboard shows no loss, duplication or per-source reordering.
//  5. Queue 6 results, assert flush 1 cycle with new pushes -> next cycle cdb_o.valid=0, src_ready=5'b11111,
//     none of the queued or flush-cycle results ever broadcast.
//  6. commit_i valid, rob_idx=5, rd_addr=2, data=32'h1234 while flush=1 -> cdb_o commit fields equal same cycle; commit_i.valid=0 -> zeros.

Source files
------------

// File: rtl/cdb_arbiter_pkg.sv
// cdb_arbiter_pkg: result, commit and common-data-bus types plus CDB source indices
package cdb_arbiter_pkg;
    localparam int ROB_IDX_W = 5;
    localparam int N_CDB_SRC = 5;
    typedef enum logic [2:0] {T_NONE, T_ALU, T_MUL, T_DIV, T_BR, T_MEM} types_t;
    // CDB source index is the producer's types_t value minus one
    localparam int CDB_SRC_ALU = int'(T_ALU) - 1;
    localparam int CDB_SRC_MUL = int'(T_MUL) - 1;
    localparam int CDB_SRC_DIV = int'(T_DIV) - 1;
    localparam int CDB_SRC_BR  = int'(T_BR) - 1;
    localparam int CDB_SRC_MEM = int'(T_MEM) - 1;
    typedef struct packed {
        logic                 valid;
        logic [31:0]          rd_data;
        logic [ROB_IDX_W-1:0] rd_rob_idx;
        logic [4:0]           rd_addr;
        logic                 regf_we;
    } to_writeback_t;
    typedef struct packed {
        logic                 valid;
        logic [31:0]          rd_data;
        logic [ROB_IDX_W-1:0] rd_rob_idx;
        logic [4:0]           rd_addr;
    } to_commit_t;
    typedef struct packed {
        logic                 valid;
        logic [31:0]          data;
        logic [ROB_IDX_W-1:0] rob_idx;
        logic [4:0]           rd_addr;
        logic                 regf_we;
        logic [31:0]          commit_data;
        logic [ROB_IDX_W-1:0] commit_rob_idx;
        logic [4:0]           commit_rd_addr;
    } cdb_t;
endpackage

// File: rtl/cdb_arbiter_if.sv
// cdb_arbiter_if: producer handshakes, ROB commit input and the common data bus
interface cdb_arbiter_if;
    import cdb_arbiter_pkg::*;
    logic [N_CDB_SRC-1:0]          src_valid;
    to_writeback_t [N_CDB_SRC-1:0] src_data;
    logic [N_CDB_SRC-1:0]          src_ready;
    to_commit_t                    commit_i;
    cdb_t                          cdb_o;
    modport master (output src_valid, src_data, commit_i, input src_ready, cdb_o);
    modport slave (input src_valid, src_data, commit_i, output src_ready, cdb_o);
endinterface

// File: rtl/cdb_src_fifo.sv
// cdb_src_fifo: small per-producer result FIFO with flush and occupancy count
module cdb_src_fifo import cdb_arbiter_pkg::*; #(
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       push,
    input  logic                       pop,
    input  to_writeback_t              din,
    output to_writeback_t              head,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    to_writeback_t mem [DEPTH];
    logic [PW-1:0] wp, rp;
    assign head = mem[rp];
    always_ff @(posedge clk) begin
        if (push && !rst && !flush)
            mem[wp] <= din;
    end
    // pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (push)
                wp <= wp + 1'b1;
            if (pop)
                rp <= rp + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end
endmodule

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: buffers execution-unit results and round-robin broadcasts one per cycle on the CDB,
// alongside a combinational pass-through of the ROB commit info.
module cdb_arbiter import cdb_arbiter_pkg::*; #(
    parameter int FIFO_DEPTH = 2
) (
    input logic          clk,
    input logic          rst,
    input logic          flush,
    cdb_arbiter_if.slave bus
);
    localparam int N_SRC = N_CDB_SRC;
    localparam int GW = $clog2(N_SRC);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    logic [CW-1:0]    count [N_SRC];
    to_writeback_t    head [N_SRC];
    logic [N_SRC-1:0] push, pop, nonempty, ready;
    logic [GW-1:0]    last_grant, winner, idx;
    logic             found;
    to_writeback_t    bc;
    assign bus.src_ready = ready;
    for (genvar i = 0; i < N_SRC; i++) begin : g_src
        assign nonempty[i] = count[i] != '0;
        assign ready[i] = (count[i] < CW'(FIFO_DEPTH)) && !flush && !rst;
        assign push[i] = bus.src_valid[i] && ready[i] && bus.src_data[i].valid;
        assign pop[i] = found && (winner == GW'(i));
        cdb_src_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .flush (flush),
            .push  (push[i]),
            .pop   (pop[i]),
            .din   (bus.src_data[i]),
            .head  (head[i]),
            .count (count[i])
        );
    end
    // search begins one past the previous winner so every source gets a turn
    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx    = '0;
        for (int k = 1; k <= N_SRC; k++) begin
            idx = GW'((int'(last_grant) + k) % N_SRC);
            if (!found && nonempty[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= GW'(N_SRC - 1);
            bc         <= '0;
        end else if (flush) begin
            bc <= '0;
        end else begin
            bc <= found ? head[winner] : '0;
            if (found)
                last_grant <= winner;
        end
    end
    always_comb begin
        bus.cdb_o                = '0;
        bus.cdb_o.valid          = bc.valid;
        bus.cdb_o.data           = bc.rd_data;
        bus.cdb_o.rob_idx        = bc.rd_rob_idx;
        bus.cdb_o.rd_addr        = bc.rd_addr;
        bus.cdb_o.regf_we        = bc.regf_we;
        bus.cdb_o.commit_data    = bus.commit_i.valid ? bus.commit_i.rd_data : '0;
        bus.cdb_o.commit_rob_idx = bus.commit_i.valid ? bus.commit_i.rd_rob_idx : '0;
        bus.cdb_o.commit_rd_addr = bus.commit_i.valid ? bus.commit_i.rd_addr : '0;
    end
endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: directed table, corner sequences and random traffic against a queue-based model
module tb_cdb_arbiter;
    import cdb_arbiter_pkg::*;
    localparam int N = N_CDB_SRC;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic flush = 1'b0;
    cdb_arbiter_if bus();
    cdb_arbiter #(.FIFO_DEPTH(2)) dut (.clk(clk), .rst(rst), .flush(flush), .bus(bus));
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    to_writeback_t mq [N][$];
    int mlg = N - 1;
    to_writeback_t exp_bc;
    logic [N-1:0] exp_ready;
    int mpush = 0;
    int nbc = 0;
    int grants [N];
    int dropped;

    typedef struct {
        logic r, f;
        logic [4:0] vm;
        int tag;
        logic [4:0] ready;
        logic v;
        int src, stag;
    } row_t;
    row_t tab [12];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic to_writeback_t mk(input int src, input int tag);
        to_writeback_t w;
        w.valid      = 1'b1;
        w.rd_data    = 32'hA000_0000 | (32'(tag) << 8) | 32'(src);
        w.rd_rob_idx = 5'(tag * 5 + src);
        w.rd_addr    = 5'(src + 1);
        w.regf_we    = (src != 3);
        return w;
    endfunction

    function automatic logic [63:0] wb_vec(input to_writeback_t w);
        return 64'({w.valid, w.rd_data, w.rd_rob_idx, w.rd_addr, w.regf_we});
    endfunction

    function automatic logic [63:0] bc_vec();
        return 64'({bus.cdb_o.valid, bus.cdb_o.data, bus.cdb_o.rob_idx, bus.cdb_o.rd_addr, bus.cdb_o.regf_we});
    endfunction

    function automatic logic [63:0] commit_vec();
        return 64'({bus.cdb_o.commit_data, bus.cdb_o.commit_rob_idx, bus.cdb_o.commit_rd_addr});
    endfunction

    // checks combinational outputs, then advances the model across the coming edge
    task automatic pre_edge();
        to_writeback_t nb;
        int w;
        #1;
        for (int i = 0; i < N; i++)
            exp_ready[i] = !rst && !flush && (mq[i].size() < 2);
        chk("src_ready", 64'(bus.src_ready), 64'(exp_ready));
        chk("commit", commit_vec(), bus.commit_i.valid ?
            64'({bus.commit_i.rd_data, bus.commit_i.rd_rob_idx, bus.commit_i.rd_addr}) : 64'd0);
        nb = '0;
        if (rst) begin
            for (int i = 0; i < N; i++) mq[i].delete();
            mlg = N - 1;
        end else if (flush) begin
            for (int i = 0; i < N; i++) mq[i].delete();
        end else begin
            w = -1;
            for (int k = 1; k <= N; k++)
                if (w < 0 && mq[(mlg + k) % N].size() > 0) w = (mlg + k) % N;
            if (w >= 0) begin
                nb = mq[w].pop_front();
                mlg = w;
            end
            for (int i = 0; i < N; i++)
                if (bus.src_valid[i] && exp_ready[i] && bus.src_data[i].valid) begin
                    mq[i].push_back(bus.src_data[i]);
                    mpush++;
                end
        end
        exp_bc = nb;
    endtask

    task automatic post_edge();
        @(posedge clk);
        #1;
        chk("bcast", bc_vec(), wb_vec(exp_bc));
        if (bus.cdb_o.valid) nbc++;
    endtask

    initial begin
        bus.src_valid = '0;
        bus.src_data  = '0;
        bus.commit_i  = '0;
        tab[0]  = '{1, 0, 5'b00000, 0, 5'b00000, 0, 0, 0};
        tab[1]  = '{1, 0, 5'b00000, 0, 5'b00000, 0, 0, 0};
        tab[2]  = '{0, 0, 5'b00000, 0, 5'b11111, 0, 0, 0};
        tab[3]  = '{0, 0, 5'b11111, 1, 5'b11111, 0, 0, 0};
        tab[4]  = '{0, 0, 5'b00000, 0, 5'b11111, 1, 0, 1};
        tab[5]  = '{0, 0, 5'b00000, 0, 5'b11111, 1, 1, 1};
        tab[6]  = '{0, 0, 5'b00000, 0, 5'b11111, 1, 2, 1};
        tab[7]  = '{0, 0, 5'b00000, 0, 5'b11111, 1, 3, 1};
        tab[8]  = '{0, 0, 5'b00000, 0, 5'b11111, 1, 4, 1};
        tab[9]  = '{0, 0, 5'b00010, 2, 5'b11111, 0, 0, 0};
        tab[10] = '{0, 0, 5'b00000, 0, 5'b11111, 1, 1, 2};
        tab[11] = '{0, 0, 5'b00000, 0, 5'b11111, 0, 0, 0};
        for (int r = 0; r < 12; r++) begin
            rst = tab[r].r;
            flush = tab[r].f;
            bus.src_valid = tab[r].vm;
            for (int i = 0; i < N; i++) bus.src_data[i] = mk(i, tab[r].tag);
            pre_edge();
            chk($sformatf("tab%0d_ready", r), 64'(bus.src_ready), 64'(tab[r].ready));
            post_edge();
            chk($sformatf("tab%0d_bc", r), bc_vec(),
                tab[r].v ? wb_vec(mk(tab[r].src, tab[r].stag)) : 64'd0);
        end

        // two-edge latency of a single alu result, broadcast exactly once
        bus.src_valid = 5'b00001;
        bus.src_data[0] = '{valid: 1'b1, rd_data: 32'hDEADBEEF, rd_rob_idx: 5'd3, rd_addr: 5'd7, regf_we: 1'b1};
        pre_edge();
        post_edge();
        chk("lat_edge_k", 64'(bus.cdb_o.valid), 64'd0);
        bus.src_valid = '0;
        pre_edge();
        post_edge();
        chk("lat_edge_k1", bc_vec(), 64'({1'b1, 32'hDEADBEEF, 5'd3, 5'd7, 1'b1}));
        pre_edge();
        post_edge();
        chk("lat_once", 64'(bus.cdb_o.valid), 64'd0);

        // payload marked invalid is never buffered
        bus.src_valid = 5'b00100;
        bus.src_data[2] = mk(2, 7);
        bus.src_data[2].valid = 1'b0;
        pre_edge();
        post_edge();
        bus.src_valid = '0;
        pre_edge();
        post_edge();
        chk("invalid_payload", 64'(bus.cdb_o.valid), 64'd0);

        // saturation: every source pushes every cycle
        mpush = 0;
        nbc = 0;
        dropped = 0;
        for (int i = 0; i < N; i++) grants[i] = 0;
        for (int c = 1; c <= 20; c++) begin
            bus.src_valid = '1;
            for (int i = 0; i < N; i++) bus.src_data[i] = mk(i, 10 + c);
            pre_edge();
            if (bus.src_ready != 5'b11111) dropped++;
            post_edge();
            if (c >= 6 && bus.cdb_o.valid) grants[bus.cdb_o.data[3:0]]++;
        end
        bus.src_valid = '0;
        repeat (12) begin
            pre_edge();
            post_edge();
        end
        chk("sat_ready_drop", 64'(dropped > 0), 64'd1);
        for (int i = 0; i < N; i++) chk($sformatf("sat_grants_src%0d", i), 64'(grants[i]), 64'd3);
        chk("sat_no_loss", 64'(nbc), 64'(mpush));

        // flush squashes queued and same-cycle results; commit still passes through
        bus.src_valid = '1;
        for (int i = 0; i < N; i++) bus.src_data[i] = mk(i, 40);
        pre_edge();
        post_edge();
        for (int i = 0; i < N; i++) bus.src_data[i] = mk(i, 41);
        pre_edge();
        post_edge();
        flush = 1'b1;
        for (int i = 0; i < N; i++) bus.src_data[i] = mk(i, 42);
        bus.commit_i = '{valid: 1'b1, rd_data: 32'h1234, rd_rob_idx: 5'd5, rd_addr: 5'd2};
        pre_edge();
        chk("flush_ready", 64'(bus.src_ready), 64'd0);
        chk("commit_on_flush", commit_vec(), 64'({32'h1234, 5'd5, 5'd2}));
        nbc = 0;
        post_edge();
        chk("flush_valid", 64'(bus.cdb_o.valid), 64'd0);
        flush = 1'b0;
        bus.src_valid = '0;
        bus.commit_i.valid = 1'b0;
        pre_edge();
        chk("post_flush_ready", 64'(bus.src_ready), 64'h1f);
        chk("commit_zero", commit_vec(), 64'd0);
        post_edge();
        repeat (6) begin
            pre_edge();
            post_edge();
        end
        chk("flush_no_bcast", 64'(nbc), 64'd0);

        // random traffic with occasional flush and reset
        for (int c = 0; c < 400; c++) begin
            to_writeback_t w;
            rst = ($urandom_range(0, 149) == 0);
            flush = ($urandom_range(0, 24) == 0);
            bus.src_valid = 5'($urandom & $urandom);
            for (int i = 0; i < N; i++) begin
                w.valid      = ($urandom_range(0, 7) != 0);
                w.rd_data    = $urandom;
                w.rd_rob_idx = 5'($urandom);
                w.rd_addr    = 5'($urandom);
                w.regf_we    = 1'($urandom);
                bus.src_data[i] = w;
            end
            bus.commit_i.valid      = 1'($urandom);
            bus.commit_i.rd_data    = $urandom;
            bus.commit_i.rd_rob_idx = 5'($urandom);
            bus.commit_i.rd_addr    = 5'($urandom);
            pre_edge();
            post_edge();
        end
        rst = 1'b0;
        flush = 1'b0;
        bus.src_valid = '0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
